matrix_window_ctrl: RTL and testbench
=====================================

# matrix_window_ctrl

Frame/line sequencer for the 3X3 matrix generator datapath. It watches the CMOS-style `per_frame_vsync`/`per_frame_href` stream and tracks pixel column and row. It drives the write/read enables, addresses and rotation select of a three-line buffer bank, and flags when a full 3x3 window is available, with its centre coordinate and border position. It sits between the camera interface and the line-buffer/matrix datapath, and replaces free-running per-line counting in that datapath.

## Interface
- `IMG_HDISP`, 640, active pixels per line.
- `IMG_VDISP`, 480, active lines per frame.
- `CMOS_VSYNC_VALID`, 1'b1, level of `per_frame_vsync` that marks the active frame.
- `AW`, $clog2(IMG_HDISP), column/address width (derived, not overridden).
- `VW`, $clog2(IMG_VDISP), row width (derived, not overridden).

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `per_frame_vsync`  in  1  frame valid, polarity per `CMOS_VSYNC_VALID`.
- `per_frame_href`  in  1  high = pixel valid this cycle.
- `lb_wr_en`  out  1  write current pixel into line buffer `lb_wr_sel`.
- `lb_wr_sel`  out  2  line buffer being written (0,1,2).
- `lb_addr`  out  AW  shared read/write address (= column).
- `lb_rd_en`  out  1  read the other two buffers at `lb_addr` (read-before-write).
- `col_cnt`  out  AW  column of the current pixel.
- `row_cnt`  out  VW  row of the current pixel.
- `win_valid`  out  1  full 3x3 window available.
- `win_x`  out  AW  window centre column (`col_cnt`-1).
- `win_y`  out  VW  window centre row (`row_cnt`-1).
- `win_left`, `win_right`, `win_top`, `win_bottom`  out  1 each  centre lies on the first/last valid centre column/row.
- `frame_start`  out  1  one-cycle pulse.
- `frame_done`  out  1  one-cycle pulse.
- `err_hlen`  out  1  sticky: a line was shorter or longer than `IMG_HDISP`.
- `err_vlen`  out  1  sticky: the frame line count was not `IMG_VDISP`.

## Operation
- Both inputs are registered once (`s_vs`, `s_hr`). Edges are detected against the previous registered value.
- The FSM has two states: IDLE and ACTIVE.
- IDLE → ACTIVE on a rising edge of `s_vs` into the valid level.
  - Pulse `frame_start`.
  - Clear `col_cnt`, `row_cnt`, `lb_wr_sel`, `err_hlen` and `err_vlen`.
- A frame already in progress at reset release (vsync already valid, no edge seen) is ignored entirely.
- In ACTIVE, each `s_hr`=1 cycle is one pixel.
  - If `col_cnt` < `IMG_HDISP`: assert `lb_wr_en`, set `lb_addr`=`col_cnt`, then `col_cnt`++.
  - Else: the pixel is dropped, `col_cnt` saturates and `err_hlen` is set.
  - `lb_rd_en` = `lb_wr_en` && `row_cnt` ≥ 1.
- Line end (falling edge of `s_hr`) in ACTIVE:
  - If the pixel count ≠ `IMG_HDISP`, set `err_hlen`.
  - `row_cnt`++, saturating at `IMG_VDISP`.
  - `lb_wr_sel` rotates 0→1→2→0.
  - `col_cnt` ← 0.
- Lines arriving after `row_cnt` = `IMG_VDISP` are not written; `err_vlen` is set.
- `win_valid` = pixel accepted && `row_cnt` ≥ 2 && `col_cnt` ≥ 2. This gives a valid-only window: (`IMG_HDISP`-2) × (`IMG_VDISP`-2) windows per frame.
- Border flags are valid only with `win_valid`:
  - `win_left` = `win_x`==1
  - `win_right` = `win_x`==`IMG_HDISP`-2
  - `win_top` = `win_y`==1
  - `win_bottom` = `win_y`==`IMG_VDISP`-2
- Vsync leaving the valid level in ACTIVE:
  - Pulse `frame_done`.
  - Set `err_vlen` if the completed line count ≠ `IMG_VDISP`.
  - Go to IDLE.
- Simultaneous href fall and vsync fall: the line end is processed first, so the vlen check includes that line.
- Href activity while in IDLE is ignored; all enables stay 0.
- Error flags hold until the next `frame_start`.

## Timing
- Latency: raw input at clock edge N → registered at edge N → every output updated at edge N+1. The datapath delays pixel data by 2 cycles to align with `lb_wr_en`/`win_valid`.
- All outputs are registered, with no combinational input→output path.
- Reset (async assert, sync release):
  - Every output is 0; `lb_wr_sel`=0; FSM in IDLE.
  - Asserting reset mid-frame aborts the frame with no `frame_done`.
- `frame_start` and `frame_done` are high for exactly 1 cycle and never in the same cycle.
- Buffers use read-before-write at the same address in the same cycle. The two non-written buffers, oldest first, supply rows `win_y`-1 and `win_y`.

## Test plan
- Nominal frame, H=16, V=5, VSYNC_VALID=1, 2-cycle href gaps → 80 `lb_wr_en`, 42 `win_valid`, exactly 1 each of `frame_start`/`frame_done`, no errors, `lb_wr_sel` returns to 2 → 0 after line 5 wraps.
- Border check on the same frame → `win_left` seen 3 times with `win_x`=1, `win_right` with `win_x`=14, `win_top` 14 times with `win_y`=1, `win_bottom` 14 times with `win_y`=3.
- Line 3 with 15 pixels → `err_hlen`=1 from that line end until the next `frame_start`; the next frame clean → both errors 0.
- 6 lines in a frame → 6th line has no `lb_wr_en`, `err_vlen`=1 at `frame_done`. 4 lines in a frame → `err_vlen`=1.
- Reset pulsed in the middle of line 2 → all outputs 0 immediately. The rest of that frame produces no enables. The following frame operates normally.
- Href and vsync falling in the same cycle on the last line → `row_cnt` reaches 5, `err_vlen`=0, `frame_done` one cycle later than the `lb_wr_en` drop.

Source files
------------

// File: rtl/matrix_window_ctrl.sv
// matrix_window_ctrl: frame/line sequencer for a 3x3 window generator over a three-line buffer bank
// Ports:
//    clk, rst_n                  pixel clock, asynchronous active-low reset
//    per_frame_vsync/href        camera frame-valid / pixel-valid inputs
//    lb_wr_en/sel, lb_addr       line buffer write enable, buffer select (0..2), shared address
//    lb_rd_en                    read the two non-written buffers at lb_addr
//    col_cnt, row_cnt            column of the current pixel, completed line count
//    win_valid, win_x, win_y     full window available and its centre coordinate
//    win_left/right/top/bottom   centre on the first/last valid centre column/row
//    frame_start, frame_done     one-cycle frame pulses
//    err_hlen, err_vlen          sticky line-length / line-count errors
module matrix_window_ctrl #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter logic CMOS_VSYNC_VALID = 1'b1,
   localparam int AW = $clog2(IMG_HDISP),
   localparam int VW = $clog2(IMG_VDISP)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          per_frame_vsync,
   input  logic          per_frame_href,
   output logic          lb_wr_en,
   output logic [1:0]    lb_wr_sel,
   output logic [AW-1:0] lb_addr,
   output logic          lb_rd_en,
   output logic [AW-1:0] col_cnt,
   output logic [VW-1:0] row_cnt,
   output logic          win_valid,
   output logic [AW-1:0] win_x,
   output logic [VW-1:0] win_y,
   output logic          win_left,
   output logic          win_right,
   output logic          win_top,
   output logic          win_bottom,
   output logic          frame_start,
   output logic          frame_done,
   output logic          err_hlen,
   output logic          err_vlen
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   // counters carry one extra bit so they can saturate at IMG_HDISP / IMG_VDISP
   localparam logic [AW:0] HL = (AW+1)'(IMG_HDISP);
   localparam logic [AW:0] HR = (AW+1)'(IMG_HDISP - 2);
   localparam logic [AW:0] C1 = (AW+1)'(1);
   localparam logic [AW:0] C2 = (AW+1)'(2);
   localparam logic [VW:0] VL = (VW+1)'(IMG_VDISP);
   localparam logic [VW:0] VB = (VW+1)'(IMG_VDISP - 2);
   localparam logic [VW:0] R1 = (VW+1)'(1);
   localparam logic [VW:0] R2 = (VW+1)'(2);
   state_t state, nstate;
   logic s_vs, p_vs, s_hr, p_hr;
   logic rise, lend, start, done, pix, acc, lend_a, lend_ok, wv, n_eh, n_ev;
   logic [AW:0] cnt, n_cnt, wx;
   logic [VW:0] rcnt, n_rcnt, wy;
   logic [1:0] n_sel;
   logic [AW-1:0] n_col;
   assign rise = s_vs & ~p_vs;
   assign lend = p_hr & ~s_hr;
   assign lb_addr = col_cnt;
   assign row_cnt = rcnt[VW-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nstate;
   // a line end takes priority over vsync loss so the final line is counted before the frame closes
   always_comb
      nstate = (state == IDLE) ? (rise ? ACTIVE : IDLE) : ((~lend & ~s_vs) ? IDLE : ACTIVE);
   always_comb begin
      start   = (state == IDLE) & rise;
      lend_a  = (state == ACTIVE) & lend;
      lend_ok = lend_a & (rcnt < VL);
      done    = (state == ACTIVE) & ~lend & ~s_vs;
      pix     = (state == ACTIVE) & s_vs & s_hr;
      acc     = pix & (cnt < HL) & (rcnt < VL);
      wv      = acc & (cnt >= C2) & (rcnt >= R2);
      wx      = cnt - C1;
      wy      = rcnt - R1;
      n_cnt   = (start | lend_a) ? '0 : acc ? cnt + C1 : cnt;
      n_col   = (start | lend_a) ? '0 : acc ? cnt[AW-1:0] : col_cnt;
      n_rcnt  = start ? '0 : lend_ok ? rcnt + R1 : rcnt;
      n_sel   = start ? 2'd0 : lend_ok ? ((lb_wr_sel == 2'd2) ? 2'd0 : lb_wr_sel + 2'd1) : lb_wr_sel;
      n_eh    = ~start & (err_hlen | (pix & (rcnt < VL) & (cnt >= HL)) | (lend_ok & (cnt != HL)));
      n_ev    = ~start & (err_vlen | (pix & (rcnt >= VL)) | (done & (rcnt != VL)));
   end
   // vsync history resets to "valid" so a frame already running at reset release never looks like a rising edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s_vs        <= 1'b1;
         p_vs        <= 1'b1;
         s_hr        <= 1'b0;
         p_hr        <= 1'b0;
         cnt         <= '0;
         rcnt        <= '0;
         col_cnt     <= '0;
         lb_wr_sel   <= '0;
         lb_wr_en    <= 1'b0;
         lb_rd_en    <= 1'b0;
         win_valid   <= 1'b0;
         win_x       <= '0;
         win_y       <= '0;
         win_left    <= 1'b0;
         win_right   <= 1'b0;
         win_top     <= 1'b0;
         win_bottom  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         err_hlen    <= 1'b0;
         err_vlen    <= 1'b0;
      end else begin
         s_vs        <= (per_frame_vsync == CMOS_VSYNC_VALID);
         p_vs        <= s_vs;
         s_hr        <= per_frame_href;
         p_hr        <= s_hr;
         cnt         <= n_cnt;
         rcnt        <= n_rcnt;
         col_cnt     <= n_col;
         lb_wr_sel   <= n_sel;
         lb_wr_en    <= acc;
         lb_rd_en    <= acc & (|rcnt);
         win_valid   <= wv;
         win_x       <= acc ? wx[AW-1:0] : win_x;
         win_y       <= acc ? wy[VW-1:0] : win_y;
         win_left    <= wv & (wx == C1);
         win_right   <= wv & (wx == HR);
         win_top     <= wv & (wy == R1);
         win_bottom  <= wv & (wy == VB);
         frame_start <= start;
         frame_done  <= done;
         err_hlen    <= n_eh;
         err_vlen    <= n_ev;
      end
endmodule

// File: tb/tb_matrix_window_ctrl.sv
// tb_matrix_window_ctrl: directed checks of the frame/line sequencer on a 16x5 frame
module tb_matrix_window_ctrl;
   localparam int H = 16;
   localparam int V = 5;
   logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hr = 1'b0;
   logic lb_wr_en, lb_rd_en, win_valid, win_left, win_right, win_top, win_bottom;
   logic frame_start, frame_done, err_hlen, err_vlen;
   logic [1:0] lb_wr_sel;
   logic [3:0] lb_addr, col_cnt, win_x;
   logic [2:0] row_cnt, win_y;
   int errors = 0, checks = 0, cyc = 0, cur_line = 0;
   bit clr = 1'b1;
   int n_wr, n_rd, n_wv, n_fs, n_fd, n_both, n_lft, n_rgt, n_top, n_bot;
   int bad_flag, bad_win, bad_addr, ea, last_wr, fd_cyc;

   matrix_window_ctrl #(.IMG_HDISP(H), .IMG_VDISP(V), .CMOS_VSYNC_VALID(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hr),
      .lb_wr_en(lb_wr_en), .lb_wr_sel(lb_wr_sel), .lb_addr(lb_addr), .lb_rd_en(lb_rd_en),
      .col_cnt(col_cnt), .row_cnt(row_cnt), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
      .win_left(win_left), .win_right(win_right), .win_top(win_top), .win_bottom(win_bottom),
      .frame_start(frame_start), .frame_done(frame_done), .err_hlen(err_hlen), .err_vlen(err_vlen));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (clr) begin
         n_wr = 0; n_rd = 0; n_wv = 0; n_fs = 0; n_fd = 0; n_both = 0;
         n_lft = 0; n_rgt = 0; n_top = 0; n_bot = 0;
         bad_flag = 0; bad_win = 0; bad_addr = 0; ea = 0; last_wr = 0; fd_cyc = 0;
      end else begin
         if (lb_wr_en) begin
            n_wr++;
            last_wr = cyc;
            if (int'(lb_addr) != ea) bad_addr++;
            ea++;
         end else ea = 0;
         if (lb_rd_en) n_rd++;
         if (frame_start) n_fs++;
         if (frame_done) begin n_fd++; fd_cyc = cyc; end
         if (frame_start && frame_done) n_both++;
         if (win_valid) begin
            n_wv++;
            if (int'(win_x) != int'(lb_addr) - 1 || int'(win_y) != cur_line - 1) bad_win++;
         end
         if (win_left)   n_lft++;
         if (win_right)  n_rgt++;
         if (win_top)    n_top++;
         if (win_bottom) n_bot++;
         if (win_left   !== (win_valid && int'(win_x) == 1))     bad_flag++;
         if (win_right  !== (win_valid && int'(win_x) == H - 2)) bad_flag++;
         if (win_top    !== (win_valid && int'(win_y) == 1))     bad_flag++;
         if (win_bottom !== (win_valid && int'(win_y) == V - 2)) bad_flag++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear();
      clr = 1'b1; step(1); clr = 1'b0; cur_line = 0;
   endtask

   task automatic start_frame();
      vs = 1'b1; step(3);
   endtask

   task automatic end_frame();
      vs = 1'b0; step(4);
   endtask

   task automatic line(input int n);
      hr = 1'b1; step(n); hr = 1'b0; step(2); cur_line++;
   endtask

   function automatic int outs();
      return int'({lb_wr_en, lb_wr_sel, lb_addr, lb_rd_en, col_cnt, row_cnt, win_valid, win_x, win_y,
                   win_left, win_right, win_top, win_bottom, frame_start, frame_done, err_hlen, err_vlen});
   endfunction

   initial begin
      step(3);
      chk("reset_outputs", outs(), 0);
      rst_n = 1'b1; step(3);
      chk("idle_outputs", outs(), 0);

      clear(); start_frame();
      for (int i = 0; i < V; i++) line(H);
      end_frame();
      chk("nom_wr", n_wr, 80);
      chk("nom_rd", n_rd, 64);
      chk("nom_wv", n_wv, 42);
      chk("nom_fs", n_fs, 1);
      chk("nom_fd", n_fd, 1);
      chk("nom_start_done_overlap", n_both, 0);
      chk("nom_err_hlen", int'(err_hlen), 0);
      chk("nom_err_vlen", int'(err_vlen), 0);
      chk("nom_sel", int'(lb_wr_sel), 2);
      chk("nom_row", int'(row_cnt), 5);
      chk("nom_left", n_lft, 3);
      chk("nom_right", n_rgt, 3);
      chk("nom_top", n_top, 14);
      chk("nom_bottom", n_bot, 14);
      chk("nom_flag_coherence", bad_flag, 0);
      chk("nom_win_coord", bad_win, 0);
      chk("nom_addr_seq", bad_addr, 0);

      clear(); start_frame();
      line(H); line(H);
      chk("short_hlen_before", int'(err_hlen), 0);
      line(H - 1);
      chk("short_hlen_at_line_end", int'(err_hlen), 1);
      line(H); line(H); end_frame(); step(3);
      chk("short_hlen_held", int'(err_hlen), 1);
      chk("short_vlen", int'(err_vlen), 0);
      chk("short_wr", n_wr, 79);

      clear(); start_frame();
      chk("clean_hlen_cleared", int'(err_hlen), 0);
      for (int i = 0; i < V; i++) line(H);
      end_frame();
      chk("clean_hlen", int'(err_hlen), 0);
      chk("clean_vlen", int'(err_vlen), 0);
      chk("clean_wr", n_wr, 80);

      clear(); start_frame();
      for (int i = 0; i < 6; i++) line(H);
      end_frame();
      chk("six_wr", n_wr, 80);
      chk("six_vlen", int'(err_vlen), 1);
      chk("six_hlen", int'(err_hlen), 0);
      chk("six_row", int'(row_cnt), 5);

      clear(); start_frame();
      for (int i = 0; i < 4; i++) line(H);
      end_frame();
      chk("four_wr", n_wr, 64);
      chk("four_vlen", int'(err_vlen), 1);
      chk("four_row", int'(row_cnt), 4);

      clear(); start_frame();
      line(H);
      hr = 1'b1; step(8);
      #2 rst_n = 1'b0;
      #1 chk("midreset_outputs", outs(), 0);
      clr = 1'b1; step(2); rst_n = 1'b1; clr = 1'b0;
      step(7); hr = 1'b0; step(2);
      for (int i = 0; i < 3; i++) line(H);
      end_frame();
      chk("aborted_wr", n_wr, 0);
      chk("aborted_fs", n_fs, 0);
      chk("aborted_fd", n_fd, 0);

      clear(); start_frame();
      for (int i = 0; i < V; i++) line(H);
      end_frame();
      chk("after_reset_wr", n_wr, 80);
      chk("after_reset_wv", n_wv, 42);
      chk("after_reset_fd", n_fd, 1);
      chk("after_reset_err", int'({err_hlen, err_vlen}), 0);

      clear(); start_frame();
      for (int i = 0; i < V - 1; i++) line(H);
      hr = 1'b1; step(H);
      hr = 1'b0; vs = 1'b0; step(5);
      chk("simul_row", int'(row_cnt), 5);
      chk("simul_vlen", int'(err_vlen), 0);
      chk("simul_fd", n_fd, 1);
      chk("simul_fd_delay", fd_cyc - last_wr, 2);
      chk("simul_wr", n_wr, 80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
